// File: rtl/touch_press_conditioner_if.sv
// Connection bundle between the touch-panel side and the press conditioner.
// The conditioner takes the slave view; the panel/consumer side takes the master view.
interface touch_press_conditioner_if;
  logic        raw_valid;
  logic [31:0] raw_data;
  logic        touch_valid;
  logic [31:0] data;
  logic        busy;

  modport master (
    output raw_valid, raw_data,
    input  touch_valid, data, busy
  );

  modport slave (
    input  raw_valid, raw_data,
    output touch_valid, data, busy
  );
endinterface

// File: rtl/touch_press_conditioner.sv
// Turns a noisy touch-panel stream into one fixed-length touch_valid pulse per press,
// rejecting short glitches and coordinate jitter and holding off until the finger lifts.
//
// state    | meaning
// ---------|----------------------------------------------------------
// IDLE     | no finger; waiting for the first raw sample
// QUAL     | counting consecutive in-window samples around the anchor
// FIRE     | driving touch_valid with the accepted coordinates
// WAIT_REL | pulse done; waiting for a sustained release before re-arming
module touch_press_conditioner #(
  parameter int PRESS_CYC   = 4,
  parameter int JITTER      = 16,
  parameter int OUT_CYC     = 5,
  parameter int RELEASE_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  touch_press_conditioner_if.slave   bus
);

  localparam int MAX_AB = (PRESS_CYC > OUT_CYC) ? PRESS_CYC : OUT_CYC;
  localparam int MAX_P  = (MAX_AB > RELEASE_CYC) ? MAX_AB : RELEASE_CYC;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] PRESS_TC = CW'(PRESS_CYC - 1);
  localparam logic [CW-1:0] OUT_TC   = CW'(OUT_CYC);
  localparam logic [CW-1:0] REL_TC   = CW'(RELEASE_CYC - 1);
  localparam logic [16:0]   JIT_LIM  = 17'(JITTER);

  typedef enum logic [1:0] {IDLE, QUAL, FIRE, WAIT_REL} state_e;

  state_e        state_q;
  logic [31:0]   anchor_q;
  logic [31:0]   data_q;
  logic          touch_valid_q;
  logic          busy_q;
  logic [CW-1:0] qcnt_q;
  logic [CW-1:0] ocnt_q;
  logic [CW-1:0] rcnt_q;

  logic [16:0] raw_x, raw_y, anc_x, anc_y, dx, dy;
  logic        in_window;

  // Differences are taken one bit wider than the axis so 0x0005 vs 0xFFFF cannot wrap.
  always_comb begin
    raw_x     = {1'b0, bus.raw_data[31:16]};
    raw_y     = {1'b0, bus.raw_data[15:0]};
    anc_x     = {1'b0, anchor_q[31:16]};
    anc_y     = {1'b0, anchor_q[15:0]};
    dx        = (raw_x >= anc_x) ? (raw_x - anc_x) : (anc_x - raw_x);
    dy        = (raw_y >= anc_y) ? (raw_y - anc_y) : (anc_y - raw_y);
    in_window = (dx <= JIT_LIM) && (dy <= JIT_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      anchor_q      <= '0;
      data_q        <= '0;
      touch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      qcnt_q        <= '0;
      ocnt_q        <= '0;
      rcnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.raw_valid) begin
            anchor_q <= bus.raw_data;
            qcnt_q   <= CNT_ONE;
            busy_q   <= 1'b1;
            if (PRESS_CYC == 1) begin
              data_q        <= bus.raw_data;
              touch_valid_q <= 1'b1;
              ocnt_q        <= CNT_ONE;
              state_q       <= FIRE;
            end else begin
              state_q <= QUAL;
            end
          end
        end
        QUAL: begin
          if (!bus.raw_valid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!in_window) begin
            anchor_q <= bus.raw_data;
            qcnt_q   <= CNT_ONE;
          end else if (qcnt_q == PRESS_TC) begin
            data_q        <= anchor_q;
            touch_valid_q <= 1'b1;
            ocnt_q        <= CNT_ONE;
            state_q       <= FIRE;
          end else begin
            qcnt_q <= qcnt_q + CNT_ONE;
          end
        end
        FIRE: begin
          if (ocnt_q == OUT_TC) begin
            touch_valid_q <= 1'b0;
            rcnt_q        <= '0;
            state_q       <= WAIT_REL;
          end else begin
            ocnt_q <= ocnt_q + CNT_ONE;
          end
        end
        WAIT_REL: begin
          // Any touch restarts the release count, so a held finger never re-arms.
          if (bus.raw_valid) begin
            rcnt_q <= '0;
          end else if (rcnt_q == REL_TC) begin
            rcnt_q  <= rcnt_q + CNT_ONE;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            rcnt_q <= rcnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.touch_valid = touch_valid_q;
  assign bus.data        = data_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_touch_press_conditioner.sv
// Directed bench for touch_press_conditioner using default parameters
// (PRESS_CYC=4, JITTER=16, OUT_CYC=5, RELEASE_CYC=4).
module tb_touch_press_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  touch_press_conditioner_if bus ();

  touch_press_conditioner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rises = 0;
  int high_cnt = 0;
  int rise_idx = -1;
  int step_idx = 0;
  logic prev_tv = 1'b0;

  // One clock: apply inputs, take the edge, observe 1 ns later and track pulses.
  task automatic step(input logic v, input logic [31:0] d);
    bus.raw_valid = v;
    bus.raw_data  = d;
    @(posedge clk);
    #1;
    if (bus.touch_valid && !prev_tv) begin
      rises++;
      if (rise_idx < 0) rise_idx = step_idx;
    end
    if (bus.touch_valid) high_cnt++;
    prev_tv = bus.touch_valid;
    step_idx++;
  endtask

  task automatic clr_track();
    rises = 0; high_cnt = 0; rise_idx = -1; step_idx = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL %s_drain_busy got=%b exp=0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    rst = 1'b0;
    n_cmp++;
    if ({bus.touch_valid, bus.busy, bus.data} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_state got tv=%b busy=%b data=%h exp tv=0 busy=0 data=0",
               bus.touch_valid, bus.busy, bus.data);
    end
  endtask

  task automatic test_clean_press();
    clr_track();
    for (int i = 0; i < 20; i++) step(1'b1, 32'h0064_0064);
    n_cmp++;
    if (rise_idx !== 3) begin n_err++; $display("FAIL clean_rise_idx got=%0d exp=3", rise_idx); end
    n_cmp++;
    if (high_cnt !== 5) begin n_err++; $display("FAIL clean_high_cycles got=%0d exp=5", high_cnt); end
    n_cmp++;
    if (rises !== 1) begin n_err++; $display("FAIL clean_pulse_count got=%0d exp=1", rises); end
    n_cmp++;
    if (bus.data !== 32'h0064_0064) begin n_err++; $display("FAIL clean_data got=%h exp=00640064", bus.data); end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL clean_release3_busy got=%b exp=1", bus.busy); end
    step(1'b0, 32'h0);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL clean_release4_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_glitch();
    clr_track();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h01C2_0190);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_during got=%b exp=1", bus.busy); end
    step(1'b0, 32'h0);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_after got=%b exp=0", bus.busy); end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
    n_cmp++;
    if (high_cnt !== 0) begin n_err++; $display("FAIL glitch_no_pulse got=%0d exp=0", high_cnt); end
    n_cmp++;
    if (bus.data !== 32'h0064_0064) begin n_err++; $display("FAIL glitch_data_kept got=%h exp=00640064", bus.data); end
  endtask

  task automatic test_jitter_edge_equal();
    logic [15:0] xs [4];
    xs[0] = 16'd100; xs[1] = 16'd110; xs[2] = 16'd116; xs[3] = 16'd100;
    clr_track();
    for (int i = 0; i < 4; i++) step(1'b1, {xs[i], 16'd400});
    n_cmp++;
    if (rise_idx !== 3) begin n_err++; $display("FAIL jitA_rise_idx got=%0d exp=3", rise_idx); end
    n_cmp++;
    if (bus.data !== 32'h0064_0190) begin n_err++; $display("FAIL jitA_data got=%h exp=00640190", bus.data); end
    drain("jitA");
  endtask

  task automatic test_jitter_reanchor();
    logic [15:0] xs [5];
    xs[0] = 16'd100; xs[1] = 16'd117; xs[2] = 16'd117; xs[3] = 16'd117; xs[4] = 16'd117;
    clr_track();
    for (int i = 0; i < 5; i++) step(1'b1, {xs[i], 16'd400});
    n_cmp++;
    if (rise_idx !== 4) begin n_err++; $display("FAIL jitB_rise_idx got=%0d exp=4", rise_idx); end
    n_cmp++;
    if (bus.data !== 32'h0075_0190) begin n_err++; $display("FAIL jitB_data got=%h exp=00750190", bus.data); end
    drain("jitB");
  endtask

  task automatic test_hold_rearm();
    clr_track();
    for (int i = 0; i < 50; i++) step(1'b1, 32'h0064_0190);
    n_cmp++;
    if (rises !== 1) begin n_err++; $display("FAIL hold_pulse_count got=%0d exp=1", rises); end
    clr_track();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h0064_0190);
    n_cmp++;
    if (high_cnt !== 0) begin n_err++; $display("FAIL short_release_no_pulse got=%0d exp=0", high_cnt); end
    clr_track();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h01C2_01A9);
    n_cmp++;
    if (rises !== 1 || rise_idx !== 7) begin
      n_err++; $display("FAIL rearm_pulse got rises=%0d idx=%0d exp rises=1 idx=7", rises, rise_idx);
    end
    n_cmp++;
    if (bus.data !== 32'h01C2_01A9) begin n_err++; $display("FAIL rearm_data got=%h exp=01C201A9", bus.data); end
    drain("rearm");
  endtask

  task automatic test_coord_edge();
    clr_track();
    step(1'b1, 32'h0005_0010);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hFFFF_0010);
    n_cmp++;
    if (rise_idx !== 4) begin n_err++; $display("FAIL edge_rise_idx got=%0d exp=4", rise_idx); end
    n_cmp++;
    if (bus.data !== 32'hFFFF_0010) begin n_err++; $display("FAIL edge_data got=%h exp=FFFF0010", bus.data); end
    drain("edge");
  endtask

  task automatic test_reset_mid_fire();
    clr_track();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h00C8_00C8);
    n_cmp++;
    if (bus.touch_valid !== 1'b1) begin n_err++; $display("FAIL midrst_fire_entry got=%b exp=1", bus.touch_valid); end
    rst = 1'b1;
    step(1'b1, 32'h00C8_00C8);
    rst = 1'b0;
    n_cmp++;
    if ({bus.touch_valid, bus.busy, bus.data} !== 34'h0) begin
      n_err++;
      $display("FAIL midrst_state got tv=%b busy=%b data=%h exp tv=0 busy=0 data=0",
               bus.touch_valid, bus.busy, bus.data);
    end
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    clr_track();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h012C_012C);
    n_cmp++;
    if (rise_idx !== 3 || high_cnt !== 5) begin
      n_err++; $display("FAIL midrst_repress got idx=%0d high=%0d exp idx=3 high=5", rise_idx, high_cnt);
    end
    n_cmp++;
    if (bus.data !== 32'h012C_012C) begin n_err++; $display("FAIL midrst_data got=%h exp=012C012C", bus.data); end
    drain("midrst");
  endtask

  initial begin
    bus.raw_valid = 1'b0;
    bus.raw_data  = 32'h0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_jitter_edge_equal();
    test_jitter_reanchor();
    test_hold_rearm();
    test_coord_edge();
    test_reset_mid_fire();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/touch_press_conditioner.md
Name: touch_press_conditioner

Overview:
- Sits directly upstream of the vending-machine control FSM, between the touch-panel controller and the FSM's touch_valid/data inputs.
- Turns the raw, noisy touch stream into clean press events. It rejects short glitches and coordinate jitter.
- Emits exactly one fixed-length touch_valid pulse per physical press, with stable coordinates. Repeated presses cannot occur while a finger stays down.

Parameters:
- PRESS_CYC, 4: consecutive qualifying raw samples required to accept a press (>=1).
- JITTER, 16: maximum per-axis coordinate deviation, in pixels, from the anchor sample during qualification.
- OUT_CYC, 5: cycles touch_valid is held high per accepted press (>=1).
- RELEASE_CYC, 4: consecutive raw_valid=0 cycles required before a new press can be qualified (>=1).

Ports:
- clk, input, 1: system clock (50 MHz).
- rst, input, 1: synchronous reset, active-high.
- raw_valid, input, 1: raw touch-detected level from the panel controller.
- raw_data, input, 32: raw coordinates; [31:16] = X, [15:0] = Y, both unsigned.
- touch_valid, output, 1: conditioned press pulse, registered.
- data, output, 32: accepted coordinates; [31:16] = X, [15:0] = Y; registered.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset:
  - rst sampled high forces state=IDLE, touch_valid=0, data=0, busy=0, and clears all counters and the anchor.
  - This applies in every state, including mid-FIRE: touch_valid goes low at that same edge.
- States: IDLE, QUAL, FIRE, WAIT_REL. Every output is a register; nothing combinational reaches an output.
- IDLE:
  - raw_valid=1: anchor<=raw_data, qcnt<=1, go to QUAL. If PRESS_CYC==1, go directly to FIRE with data<=raw_data.
  - Otherwise stay in IDLE.
- QUAL, on each edge:
  - raw_valid=0: go to IDLE. The glitch is dropped; no output activity.
  - raw_valid=1 and |X-anchorX|>JITTER or |Y-anchorY|>JITTER: re-anchor, anchor<=raw_data, qcnt<=1, stay in QUAL.
  - Otherwise the sample qualifies. If qcnt==PRESS_CYC-1: data<=anchor, touch_valid<=1, ocnt<=1, go to FIRE. Else qcnt<=qcnt+1.
- Jitter arithmetic:
  - Absolute difference is computed at 17 bits; no wrap at 0 or 0xFFFF.
  - A deviation exactly equal to JITTER qualifies.
- Latency: touch_valid rises at the edge that samples the PRESS_CYC-th consecutive qualifying raw sample.
- FIRE:
  - touch_valid=1 for exactly OUT_CYC cycles; raw_valid and raw_data are ignored.
  - data is stable for the whole pulse.
  - When ocnt==OUT_CYC: touch_valid<=0, rcnt<=0, go to WAIT_REL.
- WAIT_REL:
  - raw_valid=0: rcnt<=rcnt+1. On reaching RELEASE_CYC, go to IDLE.
  - raw_valid=1: rcnt<=0.
  - No pulse is ever generated from this state. A held finger produces exactly one event.
- data holds the last accepted coordinates until the next accept or reset. It is never updated outside the QUAL-to-FIRE transition.
- Counters are sized clog2(max parameter)+1 and never wrap: each saturates at its terminal value and then changes state.
- busy=1 in QUAL, FIRE and WAIT_REL.

Test Plan:
1. Clean press:
   - Stimulus: rst for 2 cycles, then raw_valid=1 with raw_data=0x0064_0064 for 20 cycles, then 0.
   - Response: touch_valid high 5 cycles, rising at the 4th sampled cycle; data=0x0064_0064; exactly one pulse.
2. Glitch rejection:
   - Stimulus: raw_valid=1 for 3 cycles (0x01C2_0190), then 0.
   - Response: touch_valid never asserts; data keeps its previous value; busy returns to 0 the cycle after the drop.
3. Jitter window:
   - Stimulus A: samples X=100,110,116,100 (Y=400) → Response A: pulse with data=0x0064_0190.
   - Stimulus B: samples X=100,117,117,117,117 → Response B: the sample at 117 re-anchors, pulse fires 4 samples later with data=0x0075_0190.
4. Hold and re-arm:
   - Stimulus: press 0x0064_0190 held 50 cycles.
   - Response: one pulse only.
   - Release 3 cycles, press again for 10 cycles → no pulse.
   - Release 4 cycles, press 0x01C2_01A9 for 10 cycles → a second pulse with data=0x01C2_01A9.
5. Coordinate edge:
   - Stimulus: anchor X=0x0005, next sample X=0xFFFF.
   - Response: treated as out-of-window (no wrap), re-anchor occurs.
6. Reset mid-operation:
   - Stimulus: assert rst during the 2nd FIRE cycle.
   - Response: touch_valid=0, data=0, busy=0 at that edge. A fresh 4-cycle press after release produces a normal pulse.
